// File: rtl/seg_pkg.sv
// Shared constants for the multiplexed 7-segment word display:
// blank/off codes and the active-low hex glyph table.
package seg_pkg;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] AN_OFF    = 8'hFF;

  // Entry n is the active-low {dp,g,f,e,d,c,b,a} pattern for hex digit n.
  localparam logic [15:0][7:0] HEX_SEG = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  function automatic logic [7:0] an_sel(input logic [2:0] idx);
    return ~(8'h01 << idx);
  endfunction
endpackage

// File: rtl/hex7seg_decode.sv
// Combinational nibble-to-segment lookup; dp stays dark in every glyph.
module hex7seg_decode
  import seg_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [7:0] o_seg
);
  assign o_seg = HEX_SEG[i_nib];
endmodule

// File: rtl/sram_word_display.sv
// Captures each word from the SRAM read controller on the rising edge of its
// valid and scans it out as 8 hex digits, with leading-zero blanking and a new-data LED.
module sram_word_display
  import seg_pkg::*;
#(
  parameter int SCAN_DIV    = 100000,
  parameter int HOLD_CYCLES = 50000000,
  parameter bit BLANK_LZ    = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_in,
  input  logic        data_vld,
  output logic [7:0]  an,
  output logic [7:0]  seg,
  output logic        new_led
);
  localparam int SCW = $clog2(SCAN_DIV);
  localparam int HCW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [SCW-1:0] SCAN_LAST = SCW'(SCAN_DIV - 1);
  localparam logic [HCW-1:0] HOLD_LOAD = HCW'(HOLD_CYCLES - 1);

  logic            r_vld_d;
  logic [31:0]     r_word;
  logic [SCW-1:0]  r_scan_cnt;
  logic [2:0]      r_idx;
  logic [HCW-1:0]  r_hold_cnt;
  logic            r_new_led;
  logic [7:0]      r_an;
  logic [7:0]      r_seg;

  logic            w_rise;
  logic            w_wrap;
  logic [31:0]     w_shifted;
  logic            w_blank;
  logic [7:0]      w_dec_seg;

  assign w_rise = data_vld & ~r_vld_d;
  assign w_wrap = (r_scan_cnt == SCAN_LAST);

  // One shifter serves both the nibble select and the leading-zero test.
  assign w_shifted = r_word >> {r_idx, 2'b00};
  assign w_blank   = BLANK_LZ && (r_idx != 3'd0) && (w_shifted == 32'd0);

  hex7seg_decode u_dec (
    .i_nib (w_shifted[3:0]),
    .o_seg (w_dec_seg)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_d <= 1'b0;
      r_word  <= 32'd0;
    end else begin
      r_vld_d <= data_vld;
      if (w_rise) r_word <= data_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_scan_cnt <= '0;
      r_idx      <= 3'd0;
    end else if (w_wrap) begin
      r_scan_cnt <= '0;
      r_idx      <= r_idx + 3'd1;
    end else begin
      r_scan_cnt <= r_scan_cnt + 1'b1;
    end
  end

  // A capture always reloads, so back-to-back captures keep the LED lit without a gap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_new_led  <= 1'b0;
      r_hold_cnt <= '0;
    end else if (w_rise) begin
      r_new_led  <= 1'b1;
      r_hold_cnt <= HOLD_LOAD;
    end else if (r_new_led) begin
      if (r_hold_cnt == '0) r_new_led  <= 1'b0;
      else                  r_hold_cnt <= r_hold_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_an  <= AN_OFF;
      r_seg <= SEG_BLANK;
    end else begin
      r_an  <= an_sel(r_idx);
      r_seg <= w_blank ? SEG_BLANK : w_dec_seg;
    end
  end

  assign an      = r_an;
  assign seg     = r_seg;
  assign new_led = r_new_led;
endmodule

// File: tb/tb_sram_word_display.sv
// Directed plus random bench for sram_word_display; a cycle-indexed model
// predicts digit, word and LED state from elapsed cycles since reset release.
module tb_sram_word_display;
  localparam int SCAN_DIV    = 4;
  localparam int HOLD_CYCLES = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data_in;
  logic        data_vld;
  logic [7:0]  an, seg, an2, seg2;
  logic        new_led, led2;

  sram_word_display #(.SCAN_DIV(SCAN_DIV), .HOLD_CYCLES(HOLD_CYCLES), .BLANK_LZ(1'b1)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .data_vld(data_vld),
    .an(an), .seg(seg), .new_led(new_led)
  );

  sram_word_display #(.SCAN_DIV(SCAN_DIV), .HOLD_CYCLES(HOLD_CYCLES), .BLANK_LZ(1'b0)) dut_nb (
    .clk(clk), .rst(rst), .data_in(data_in), .data_vld(data_vld),
    .an(an2), .seg(seg2), .new_led(led2)
  );

  always #5 clk = ~clk;

  logic [7:0] seg_tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  int          n_checks = 0;
  int          n_fail   = 0;
  int          k;            // clock edges since reset release
  int          last_cap;     // edge number of the most recent capture
  logic [31:0] m_word;
  bit          m_vld_prev;

  function automatic logic [7:0] exp_seg(input logic [31:0] w, input int d, input bit blz);
    logic [31:0] upper;
    upper = w >> (4 * d);
    if (blz && d > 0 && upper == 32'd0) return 8'hFF;
    return seg_tbl[upper[3:0]];
  endfunction

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    assert (got === exp)
      else begin
        n_fail++;
        $error("FAIL %s k=%0d got %h expected %h", tag, k, got, exp);
      end
  endtask

  task automatic chk_off(input string tag);
    chk({tag, "_an"},  an,  8'hFF);
    chk({tag, "_seg"}, seg, 8'hFF);
    chk({tag, "_led"}, {7'd0, new_led}, 8'd0);
    chk({tag, "_an2"}, an2, 8'hFF);
  endtask

  task automatic model_reset();
    k = 0; m_word = 32'd0; m_vld_prev = 1'b0; last_cap = -1000;
  endtask

  // Called #1 after an edge; rst rises between edges and must blank at once.
  task automatic do_reset(input bit check_now, input int n, input bit v);
    rst = 1'b1; data_vld = v; data_in = 32'hDEAD_BEEF;
    if (check_now) begin #1; chk_off("rst_async"); end
    repeat (n) begin @(posedge clk); #1; chk_off("rst_hold"); end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic step(input bit v, input logic [31:0] d);
    int          digit;
    logic [31:0] wprev;
    logic [7:0]  exp_an;
    logic        exp_led;
    data_vld = v; data_in = d;
    @(posedge clk);
    k++;
    digit = ((k - 1) / SCAN_DIV) % 8;
    wprev = m_word;
    if (v && !m_vld_prev) begin m_word = d; last_cap = k; end
    m_vld_prev = v;
    exp_an  = ~(8'h01 << digit);
    exp_led = (k - last_cap) < HOLD_CYCLES;
    #1;
    chk("an",   an,   exp_an);
    chk("seg",  seg,  exp_seg(wprev, digit, 1'b1));
    chk("led",  {7'd0, new_led}, {7'd0, exp_led});
    chk("an_nb",  an2,  exp_an);
    chk("seg_nb", seg2, exp_seg(wprev, digit, 1'b0));
  endtask

  initial begin
    data_vld = 1'b0; data_in = 32'd0;
    model_reset();
    do_reset(1'b0, 3, 1'b0);

    // Idle sweep on an all-zero word.
    repeat (40) step(1'b0, 32'd0);

    // Single pulse, then a full sweep and the LED tail.
    step(1'b1, 32'h1234_5678);
    repeat (39) step(1'b0, 32'd0);

    // Level held high: only the first cycle captures.
    for (int i = 0; i < 50; i++) step(1'b1, (i < 5) ? 32'h1234_5678 : 32'hFFFF_FFFF);
    repeat (15) step(1'b0, 32'd0);

    // Leading-zero blanking.
    step(1'b1, 32'h0000_00A0);
    repeat (35) step(1'b0, 32'd0);

    // Retrigger 6 cycles after the first pulse.
    step(1'b1, 32'hAAAA_5555);
    repeat (5) step(1'b0, 32'd0);
    step(1'b1, 32'h0000_BEEF);
    repeat (15) step(1'b0, 32'd0);

    // Capture on the same edge the scan counter wraps.
    while ((k % SCAN_DIV) != SCAN_DIV - 1) step(1'b0, 32'd0);
    step(1'b1, 32'h8765_4321);
    repeat (8) step(1'b0, 32'd0);

    // Mid-sweep reset with valid high; the first cycle after release captures.
    do_reset(1'b1, 3, 1'b1);
    step(1'b1, 32'h00C0_FFEE);
    repeat (3) step(1'b1, 32'h1111_1111);
    repeat (36) step(1'b0, 32'd0);

    // Random words, gaps and valid lengths.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        logic [31:0] w;
        int          len;
        w   = $urandom >> $urandom_range(0, 31);
        len = $urandom_range(1, 4);
        for (int j = 0; j < len; j++) step(1'b1, (j == 0) ? w : $urandom);
      end else begin
        step(1'b0, $urandom);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
